// File: rtl/board_cursor_ctrl.sv
// board_cursor_ctrl
// Turns debounced button pulses into a cursor position on an 8x8 board,
// latches a source square and then a destination square, and offers the
// resulting move to the game-logic stage over a valid/ready handshake.
// Every output is a register, so each input pulse shows one cycle later.

module board_cursor_ctrl #(
  parameter int WRAP   = 1,
  parameter int INIT_X = 4,
  parameter int INIT_Y = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  input  logic       flip,
  input  logic       enable,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       sel_valid,
  output logic [5:0] sel_sq,
  output logic       move_valid,
  output logic [5:0] move_from,
  output logic [5:0] move_to,
  input  logic       move_ready
);

  localparam logic [2:0] INIT_X_C = 3'(INIT_X);
  localparam logic [2:0] INIT_Y_C = 3'(INIT_Y);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SRC  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cursor_x_q, cursor_x_d;
  logic [2:0] cursor_y_q, cursor_y_d;
  logic       sel_valid_q, sel_valid_d;
  logic [5:0] sel_sq_q, sel_sq_d;
  logic       move_valid_q, move_valid_d;
  logic [5:0] move_from_q, move_from_d;
  logic [5:0] move_to_q, move_to_d;

  // Direction pulses after board orientation and centre suppression
  logic       up_s, down_s, left_s, right_s;
  logic [5:0] cursor_sq_s;

  // Step one coordinate towards 7; at the edge wrap or saturate
  function automatic logic [2:0] step_inc(input logic [2:0] v);
    logic [2:0] r;
    if (v == 3'd7) begin
      r = (WRAP != 0) ? 3'd0 : 3'd7;
    end else begin
      r = v + 3'd1;
    end
    return r;
  endfunction

  // Step one coordinate towards 0; at the edge wrap or saturate
  function automatic logic [2:0] step_dec(input logic [2:0] v);
    logic [2:0] r;
    if (v == 3'd0) begin
      r = (WRAP != 0) ? 3'd7 : 3'd0;
    end else begin
      r = v - 3'd1;
    end
    return r;
  endfunction

  // Resolve orientation: seen from black every direction is mirrored; a centre press masks all moves
  always_comb begin
    up_s    = 1'b0;
    down_s  = 1'b0;
    left_s  = 1'b0;
    right_s = 1'b0;
    if (btn_center) begin
      up_s    = 1'b0;
      down_s  = 1'b0;
      left_s  = 1'b0;
      right_s = 1'b0;
    end else if (flip) begin
      up_s    = btn_down;
      down_s  = btn_up;
      left_s  = btn_right;
      right_s = btn_left;
    end else begin
      up_s    = btn_up;
      down_s  = btn_down;
      left_s  = btn_left;
      right_s = btn_right;
    end
  end

  // Cursor next position: axes independent, opposite pulses cancel on their axis
  always_comb begin
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    if (right_s && !left_s) begin
      cursor_x_d = step_inc(cursor_x_q);
    end else if (left_s && !right_s) begin
      cursor_x_d = step_dec(cursor_x_q);
    end else begin
      cursor_x_d = cursor_x_q;
    end
    if (up_s && !down_s) begin
      cursor_y_d = step_inc(cursor_y_q);
    end else if (down_s && !up_s) begin
      cursor_y_d = step_dec(cursor_y_q);
    end else begin
      cursor_y_d = cursor_y_q;
    end
  end

  assign cursor_sq_s = {cursor_y_q, cursor_x_q};

  // Selection FSM: pick source, pick destination, hold the move until accepted
  always_comb begin
    state_d      = state_q;
    sel_valid_d  = sel_valid_q;
    sel_sq_d     = sel_sq_q;
    move_valid_d = move_valid_q;
    move_from_d  = move_from_q;
    move_to_d    = move_to_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_center && enable) begin
          state_d     = ST_SRC;
          sel_valid_d = 1'b1;
          sel_sq_d    = cursor_sq_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SRC: begin
        // Losing the turn abandons the selection even if centre is pressed now
        if (!enable) begin
          state_d     = ST_IDLE;
          sel_valid_d = 1'b0;
        end else if (btn_center) begin
          if (cursor_sq_s == sel_sq_q) begin
            state_d     = ST_IDLE;
            sel_valid_d = 1'b0;
          end else begin
            state_d      = ST_PEND;
            move_valid_d = 1'b1;
            move_from_d  = sel_sq_q;
            move_to_d    = cursor_sq_s;
          end
        end else begin
          state_d = ST_SRC;
        end
      end
      ST_PEND: begin
        if (move_valid_q && move_ready) begin
          state_d      = ST_IDLE;
          move_valid_d = 1'b0;
          sel_valid_d  = 1'b0;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        sel_valid_d  = 1'b0;
        move_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cursor_x_q   <= INIT_X_C;
      cursor_y_q   <= INIT_Y_C;
      sel_valid_q  <= 1'b0;
      sel_sq_q     <= 6'd0;
      move_valid_q <= 1'b0;
      move_from_q  <= 6'd0;
      move_to_q    <= 6'd0;
    end else begin
      state_q      <= state_d;
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
      sel_valid_q  <= sel_valid_d;
      sel_sq_q     <= sel_sq_d;
      move_valid_q <= move_valid_d;
      move_from_q  <= move_from_d;
      move_to_q    <= move_to_d;
    end
  end

  assign cursor_x   = cursor_x_q;
  assign cursor_y   = cursor_y_q;
  assign sel_valid  = sel_valid_q;
  assign sel_sq     = sel_sq_q;
  assign move_valid = move_valid_q;
  assign move_from  = move_from_q;
  assign move_to    = move_to_q;

endmodule
